// File: rtl/mem_and_mdr.sv
// Memory stage of the SAP-2 datapath: 2^AW x DW synchronous RAM plus the memory data register.
// Define MEM_CLEAR_EN to build in the post-reset clear sweep that zeroes the RAM before accepting requests.
module mem_and_mdr #(
    parameter int AW = 8,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          clr_n,
    input  logic [AW-1:0] addr,
    input  logic          prog,
    input  logic [DW-1:0] sw_data,
    input  logic          sw_wr,
    input  logic [DW-1:0] bus_in,
    input  logic          lmdr,
    input  logic          rd,
    input  logic          wr,
    output logic [DW-1:0] mdr,
    output logic          busy,
    output logic          wr_done
);

    logic [DW-1:0] mem [2**AW];

    logic [DW-1:0] mdr_q, mdr_d;
    logic          swHist_q;
    logic          wrDone_q, wrDone_d;

    logic          sweepWe;
    logic [AW-1:0] sweepAddr;

    logic          swRise;
    logic          progWr;
    logic          runAct;
    logic          memWe;
    logic [AW-1:0] memAddr;
    logic [DW-1:0] memWdata;
    logic [DW-1:0] memRdata;

`ifdef MEM_CLEAR_EN
    typedef enum logic {CLEAR, IDLE} state_e;

    state_e        state_q, state_d;
    logic [AW-1:0] clrCnt_q, clrCnt_d;

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q  <= CLEAR;
            clrCnt_q <= '0;
        end else begin
            state_q  <= state_d;
            clrCnt_q <= clrCnt_d;
        end
    end

    // The edge that clears the last address hands control back to the datapath.
    always_comb begin
        state_d  = state_q;
        clrCnt_d = clrCnt_q;
        if (state_q == CLEAR) begin
            clrCnt_d = clrCnt_q + 1'b1;
            if (clrCnt_q == '1) begin
                state_d = IDLE;
            end
        end
    end

    always_comb begin
        busy      = (state_q == CLEAR);
        sweepWe   = (state_q == CLEAR);
        sweepAddr = clrCnt_q;
    end
`else
    assign busy      = 1'b0;
    assign sweepWe   = 1'b0;
    assign sweepAddr = '0;
`endif

    // The history register tracks the button even while busy, so a press during the sweep is consumed.
    assign swRise   = sw_wr & ~swHist_q;
    assign progWr   = ~busy & prog & swRise;
    assign runAct   = ~busy & ~prog;
    assign memRdata = mem[addr];

    always_comb begin
        memWe    = 1'b0;
        memAddr  = addr;
        memWdata = mdr_q;
        if (sweepWe) begin
            memWe    = 1'b1;
            memAddr  = sweepAddr;
            memWdata = '0;
        end else if (progWr) begin
            memWe    = 1'b1;
            memWdata = sw_data;
        end else if (runAct && wr) begin
            memWe    = 1'b1;
        end
    end

    // memRdata is the pre-edge contents, which gives read-before-write when rd and wr coincide.
    always_comb begin
        mdr_d    = mdr_q;
        wrDone_d = progWr;
        if (progWr) begin
            mdr_d = sw_data;
        end else if (runAct && lmdr) begin
            mdr_d = bus_in;
        end else if (runAct && rd) begin
            mdr_d = memRdata;
        end
    end

    always_ff @(posedge clk) begin
        if (memWe) begin
            mem[memAddr] <= memWdata;
        end
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            mdr_q    <= '0;
            swHist_q <= 1'b1;
            wrDone_q <= 1'b0;
        end else begin
            mdr_q    <= mdr_d;
            swHist_q <= sw_wr;
            wrDone_q <= wrDone_d;
        end
    end

    assign mdr     = mdr_q;
    assign wr_done = wrDone_q;

endmodule

// File: tb/tb_mem_and_mdr.sv
// Scoreboard bench for mem_and_mdr: a behavioural model predicts mdr/wr_done/busy per edge.
// Honours MEM_CLEAR_EN the same way the design does.
module tb_mem_and_mdr;

    localparam int AW    = 8;
    localparam int DW    = 8;
    localparam int DEPTH = 2**AW;

    logic          clk;
    logic          clr_n;
    logic [AW-1:0] addr;
    logic          prog;
    logic [DW-1:0] sw_data;
    logic          sw_wr;
    logic [DW-1:0] bus_in;
    logic          lmdr;
    logic          rd;
    logic          wr;
    logic [DW-1:0] mdr;
    logic          busy;
    logic          wr_done;

    mem_and_mdr #(.AW(AW), .DW(DW)) dut (
        .clk     (clk),
        .clr_n   (clr_n),
        .addr    (addr),
        .prog    (prog),
        .sw_data (sw_data),
        .sw_wr   (sw_wr),
        .bus_in  (bus_in),
        .lmdr    (lmdr),
        .rd      (rd),
        .wr      (wr),
        .mdr     (mdr),
        .busy    (busy),
        .wr_done (wr_done)
    );

    typedef struct {
        string         tag;
        logic [DW-1:0] mdr;
        logic          done;
        logic          busy;
    } exp_t;

    exp_t sbQ[$];

    int checkCount = 0;
    int errorCount = 0;

    logic [DW-1:0] modelMem [DEPTH];
    logic [DW-1:0] modelMdr;
    logic          modelHist;
    logic          modelDone;
    int            sweepLeft;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
        end
    endtask

    // Drive one edge's worth of inputs at a negedge, predict the post-edge outputs, then advance.
    task automatic applyStimulus(input string tag, input logic p, input logic [AW-1:0] a,
                                 input logic [DW-1:0] sd, input logic sw, input logic [DW-1:0] b,
                                 input logic l, input logic r, input logic w);
        logic [DW-1:0] oldMem;
        prog = p; addr = a; sw_data = sd; sw_wr = sw; bus_in = b; lmdr = l; rd = r; wr = w;
        if (sweepLeft > 0) begin
            modelMem[DEPTH - sweepLeft] = '0;
            sweepLeft--;
            modelDone = 1'b0;
        end else if (p) begin
            modelDone = 1'b0;
            if (sw && !modelHist) begin
                modelMem[a] = sd;
                modelMdr    = sd;
                modelDone   = 1'b1;
            end
        end else begin
            oldMem = modelMem[a];
            if (w) modelMem[a] = modelMdr;
            if (l) modelMdr = b;
            else if (r) modelMdr = oldMem;
            modelDone = 1'b0;
        end
        modelHist = sw;
        sbQ.push_back('{tag, modelMdr, modelDone, logic'(sweepLeft > 0)});
        @(negedge clk);
    endtask

    task automatic applyReset(input logic holdSw);
        clr_n = 1'b0;
        sw_wr = holdSw; lmdr = 1'b0; rd = 1'b0; wr = 1'b0;
        #1;
        checkOutput("reset/mdr", 32'(mdr), 32'h0);
        checkOutput("reset/wr_done", 32'(wr_done), 32'h0);
`ifdef MEM_CLEAR_EN
        checkOutput("reset/busy", 32'(busy), 32'h1);
`else
        checkOutput("reset/busy", 32'(busy), 32'h0);
`endif
        @(negedge clk);
        @(negedge clk);
        clr_n     = 1'b1;
        modelMdr  = '0;
        modelHist = 1'b1;
        modelDone = 1'b0;
`ifdef MEM_CLEAR_EN
        sweepLeft = DEPTH;
`else
        sweepLeft = 0;
`endif
    endtask

    // Requests issued here while the sweep runs must all be dropped.
    task automatic waitIdle(input logic p, input logic sw);
        for (int i = 0; i < DEPTH + 8 && sweepLeft > 0; i++) begin
            applyStimulus("sweep", p, AW'(i), 8'hEE, sw, 8'h5A, 1'b1, 1'b1, 1'b1);
        end
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (sbQ.size() > 0) begin
            e = sbQ.pop_front();
            checkOutput({e.tag, "/mdr"}, 32'(mdr), 32'(e.mdr));
            checkOutput({e.tag, "/wr_done"}, 32'(wr_done), 32'(e.done));
            checkOutput({e.tag, "/busy"}, 32'(busy), 32'(e.busy));
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete, checks=%0d", checkCount);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        for (int i = 0; i < DEPTH; i++) modelMem[i] = 'x;
        modelMdr = '0; modelHist = 1'b1; modelDone = 1'b0; sweepLeft = 0;
        clr_n = 1'b0; prog = 1'b0; addr = '0; sw_data = '0; sw_wr = 1'b0;
        bus_in = '0; lmdr = 1'b0; rd = 1'b0; wr = 1'b0;
        @(negedge clk);
        applyReset(1'b0);
        waitIdle(1'b0, 1'b0);

        $display("[TB] program-mode switch write");
        applyStimulus("prog_arm", 1'b1, 8'd5, 8'h3C, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++)
            applyStimulus("prog_hold", 1'b1, 8'd5, 8'h3C, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
        applyStimulus("prog_rel", 1'b1, 8'd5, 8'h3C, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

        $display("[TB] run-mode load/write/read");
        applyStimulus("lmdr_a5", 1'b0, 8'd0, 8'h00, 1'b0, 8'hA5, 1'b1, 1'b0, 1'b0);
        applyStimulus("wr_9", 1'b0, 8'd9, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        applyStimulus("lmdr_0", 1'b0, 8'd9, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        applyStimulus("rd_9", 1'b0, 8'd9, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        applyStimulus("rd_5", 1'b0, 8'd5, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);

        $display("[TB] priority and read-before-write");
        applyStimulus("ld22", 1'b0, 8'd20, 8'h00, 1'b0, 8'h22, 1'b1, 1'b0, 1'b0);
        applyStimulus("wr20", 1'b0, 8'd20, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        applyStimulus("lmdr_over_rd", 1'b0, 8'd20, 8'h00, 1'b0, 8'h11, 1'b1, 1'b1, 1'b0);
        applyStimulus("ld33", 1'b0, 8'd21, 8'h00, 1'b0, 8'h33, 1'b1, 1'b0, 1'b0);
        applyStimulus("wr21", 1'b0, 8'd21, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        applyStimulus("ld11", 1'b0, 8'd21, 8'h00, 1'b0, 8'h11, 1'b1, 1'b0, 1'b0);
        applyStimulus("rd_wr21", 1'b0, 8'd21, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
        applyStimulus("rd21", 1'b0, 8'd21, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);

        $display("[TB] mode gating");
        applyStimulus("prog_gate", 1'b1, 8'd21, 8'h00, 1'b0, 8'h77, 1'b1, 1'b1, 1'b1);
        applyStimulus("rd21_again", 1'b0, 8'd21, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        applyStimulus("run_sw_low", 1'b0, 8'd5, 8'h77, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        applyStimulus("run_sw_rise", 1'b0, 8'd5, 8'h77, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
        applyStimulus("rd5_kept", 1'b0, 8'd5, 8'h00, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0);

        $display("[TB] reset with button held");
        prog = 1'b1; addr = 8'd5; sw_data = 8'h99;
        applyReset(1'b1);
        waitIdle(1'b1, 1'b1);
        for (int i = 0; i < 3; i++)
            applyStimulus("held", 1'b1, 8'd5, 8'h99, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
        applyStimulus("rd5_post", 1'b0, 8'd5, 8'h00, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0);
        applyStimulus("rearm", 1'b1, 8'd6, 8'h99, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        applyStimulus("new_edge", 1'b1, 8'd6, 8'h99, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
        applyStimulus("rd6", 1'b0, 8'd6, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);

        $display("[TB] random mixed traffic");
        for (int i = 0; i < 8; i++) begin
            applyStimulus("fill_ld", 1'b0, AW'(i), 8'h00, 1'b0, DW'(8'h40 + i), 1'b1, 1'b0, 1'b0);
            applyStimulus("fill_wr", 1'b0, AW'(i), 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        end
        for (int i = 0; i < 40; i++) begin
            applyStimulus("rand", 1'($urandom_range(0, 3) == 0), AW'($urandom_range(0, 7)),
                          DW'($urandom), 1'($urandom), DW'($urandom),
                          1'($urandom), 1'($urandom), 1'($urandom));
        end

`ifdef MEM_CLEAR_EN
        $display("[TB] clear sweep");
        applyStimulus("ldff", 1'b0, 8'd200, 8'h00, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b0);
        applyStimulus("wr200", 1'b0, 8'd200, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        applyReset(1'b0);
        for (int i = 0; i < 100; i++)
            applyStimulus("partial", 1'b0, 8'd200, 8'h00, 1'b0, 8'h5A, 1'b0, 1'b1, 1'b1);
        applyReset(1'b0);
        waitIdle(1'b0, 1'b0);
        applyStimulus("rd200", 1'b0, 8'd200, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        applyStimulus("rd255", 1'b0, 8'd255, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
`endif

        applyStimulus("drain", 1'b0, 8'd0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("scoreboard_empty", 32'(sbQ.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
